// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the fetch/data memory arbiter.
// Consumed by mem_arbiter; see its header for the MEM_ARB_STARVE_EN option.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      IBUSY = 2'd1,
      DBUSY = 2'd2
   } arb_state_e;

   localparam int ADDR_W_DEF       = 32;
   localparam int DATA_W_DEF       = 32;
   localparam int STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (fetch vs. data) onto one single-port memory.
// Define MEM_ARB_STARVE_EN to bound how long data can starve fetch.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int DATA_W       = DATA_W_DEF,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ireq,
   input  logic [ADDR_W-1:0] iaddr,
   output logic [DATA_W-1:0] irdata,
   output logic              iready,
   output logic              istall,
   input  logic              dreq,
   input  logic              dwe,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [DATA_W-1:0] dwdata,
   output logic [DATA_W-1:0] drdata,
   output logic              dready,
   output logic              dstall,
   output logic              mreq,
   output logic              mwe,
   output logic [ADDR_W-1:0] maddr,
   output logic [DATA_W-1:0] mwdata,
   input  logic [DATA_W-1:0] mrdata,
   input  logic              mack
);

   arb_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   logic is_idle;
   logic starve_hit;
   logic grant_d;
   logic grant_i;

   assign is_idle = (state_q == IDLE);
   assign grant_d = is_idle && dreq && !starve_hit;
   assign grant_i = is_idle && ireq && !grant_d;

`ifdef MEM_ARB_STARVE_EN
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Counts back-to-back data grants that a pending fetch had to wait out.
   always_comb begin
      cnt_d = cnt_q;
      if (is_idle) begin
         if (!ireq || grant_i) begin
            cnt_d = '0;
         end else if (grant_d) begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign starve_hit = ireq && (cnt_q == CNT_W'(STARVE_LIMIT));
`else
   assign starve_hit = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      unique case (state_q)
         IDLE: begin
            if (grant_d) begin
               state_d = DBUSY;
               addr_d  = daddr;
               we_d    = dwe;
               wdata_d = dwdata;
            end else if (grant_i) begin
               state_d = IBUSY;
               addr_d  = iaddr;
               we_d    = 1'b0;
               wdata_d = '0;
            end
         end
         IBUSY, DBUSY: begin
            if (mack) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
      end
   end

   assign mreq   = !is_idle;
   assign mwe    = (state_q == DBUSY) && we_q;
   assign maddr  = addr_q;
   assign mwdata = wdata_q;

   // Ready follows mack combinationally so a zero-wait memory costs 2 cycles.
   assign iready = (state_q == IBUSY) && mack;
   assign dready = (state_q == DBUSY) && mack;
   assign irdata = iready ? mrdata : '0;
   assign drdata = dready ? mrdata : '0;
   assign istall = ireq && !iready;
   assign dstall = dreq && !dready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level model,
// plus directed fetch, collision, address-hold, reset and starvation runs.
module tb_mem_arbiter;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int LIM = 4;
`ifdef MEM_ARB_STARVE_EN
   localparam bit STARVE = 1'b1;
`else
   localparam bit STARVE = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          ireq;
   logic [AW-1:0] iaddr;
   logic [DW-1:0] irdata;
   logic          iready;
   logic          istall;
   logic          dreq;
   logic          dwe;
   logic [AW-1:0] daddr;
   logic [DW-1:0] dwdata;
   logic [DW-1:0] drdata;
   logic          dready;
   logic          dstall;
   logic          mreq;
   logic          mwe;
   logic [AW-1:0] maddr;
   logic [DW-1:0] mwdata;
   logic [DW-1:0] mrdata;
   logic          mack;

   always #5 clk = ~clk;

   mem_arbiter #(
      .ADDR_W(AW),
      .DATA_W(DW),
      .STARVE_LIMIT(LIM)
   ) dut (
      .clk(clk),
      .reset(reset),
      .ireq(ireq),
      .iaddr(iaddr),
      .irdata(irdata),
      .iready(iready),
      .istall(istall),
      .dreq(dreq),
      .dwe(dwe),
      .daddr(daddr),
      .dwdata(dwdata),
      .drdata(drdata),
      .dready(dready),
      .dstall(dstall),
      .mreq(mreq),
      .mwe(mwe),
      .maddr(maddr),
      .mwdata(mwdata),
      .mrdata(mrdata),
      .mack(mack)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // model: who owns the memory (0 none, 1 fetch, 2 data) and what it asked for
   int            m_busy   = 0;
   logic [AW-1:0] m_addr   = '0;
   logic          m_we     = 1'b0;
   logic [DW-1:0] m_wdata  = '0;
   int            m_starve = 0;
   bit            post_rst = 1'b0;
   bit            last_ir  = 1'b0;
   bit            last_dr  = 1'b0;
   bit            s_ir     = 1'b0;
   bit            s_dr     = 1'b0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   // One clock: compare outputs to the model, then advance the model.
   task automatic cycle(input bit chk);
      bit e_ir;
      bit e_dr;
      bit hit;
      #1;
      e_ir = (m_busy == 1) && mack;
      e_dr = (m_busy == 2) && mack;
      s_ir = iready;
      s_dr = dready;
      if (chk) begin
         check("mreq", mreq, m_busy != 0);
         check("mwe", mwe, (m_busy == 2) && m_we);
         check("iready", iready, e_ir);
         check("dready", dready, e_dr);
         check("istall", istall, ireq && !e_ir);
         check("dstall", dstall, dreq && !e_dr);
         if (m_busy != 0) check("maddr", maddr, m_addr);
         if (m_busy == 2 && m_we) check("mwdata", mwdata, m_wdata);
         if (e_ir) check("irdata", irdata, mrdata);
         if (e_dr && !m_we) check("drdata", drdata, mrdata);
         if (post_rst) begin
            check("irdata_rst", irdata, 0);
            check("drdata_rst", drdata, 0);
            post_rst = 1'b0;
         end
      end
      last_ir = e_ir && !reset;
      last_dr = e_dr && !reset;
      if (reset) begin
         m_busy   = 0;
         m_starve = 0;
         m_addr   = '0;
         m_we     = 1'b0;
         m_wdata  = '0;
         post_rst = 1'b1;
      end else if (m_busy != 0) begin
         if (mack) m_busy = 0;
      end else begin
         hit = STARVE && ireq && (m_starve >= LIM);
         if (dreq && !hit) begin
            m_busy   = 2;
            m_addr   = daddr;
            m_we     = dwe;
            m_wdata  = dwdata;
            m_starve = ireq ? m_starve + 1 : 0;
         end else if (ireq) begin
            m_busy   = 1;
            m_addr   = iaddr;
            m_we     = 1'b0;
            m_starve = 0;
         end else begin
            m_starve = 0;
         end
      end
      @(negedge clk);
   endtask

   task automatic quiet();
      ireq   = 1'b0;
      iaddr  = '0;
      dreq   = 1'b0;
      dwe    = 1'b0;
      daddr  = '0;
      dwdata = '0;
      mrdata = '0;
      mack   = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cycle(1'b0);
      reset = 1'b0;
   endtask

   initial begin
      bit i_act;
      bit d_act;
      int k;
      quiet();
      reset = 1'b1;
      @(negedge clk);
      cycle(1'b0);
      reset = 1'b0;
      cycle(1'b1);

      // single fetch
      ireq  = 1'b1;
      iaddr = 32'h0000_0040;
      #1 check("f_c0_istall", istall, 1);
      cycle(1'b1);
      check("f_c1_mreq", mreq, 1);
      check("f_c1_maddr", maddr, 32'h40);
      check("f_c1_istall", istall, 1);
      cycle(1'b1);
      mack   = 1'b1;
      mrdata = 32'h2008_0005;
      #1 check("f_c2_iready", iready, 1);
      check("f_c2_irdata", irdata, 32'h2008_0005);
      check("f_c2_istall", istall, 0);
      cycle(1'b1);
      quiet();
      #1 check("f_c3_mreq", mreq, 0);
      cycle(1'b1);

      // collision: write goes first, fetch follows
      ireq   = 1'b1;
      iaddr  = 32'h80;
      dreq   = 1'b1;
      dwe    = 1'b1;
      daddr  = 32'h54;
      dwdata = 32'h7;
      cycle(1'b1);
      mack = 1'b1;
      #1 check("col_mwe", mwe, 1);
      check("col_maddr", maddr, 32'h54);
      check("col_mwdata", mwdata, 32'h7);
      check("col_dready", dready, 1);
      check("col_istall", istall, 1);
      cycle(1'b1);
      dreq = 1'b0;
      mack = 1'b0;
      cycle(1'b1);
      mack = 1'b1;
      #1 check("col_i_maddr", maddr, 32'h80);
      check("col_i_mwe", mwe, 0);
      check("col_iready", iready, 1);
      cycle(1'b1);
      quiet();

      // address change after grant is ignored
      dreq  = 1'b1;
      daddr = 32'h10;
      cycle(1'b1);
      daddr = 32'h20;
      for (int c = 0; c < 4; c++) begin
         mack = (c == 3);
         #1 check("hold_maddr", maddr, 32'h10);
         cycle(1'b1);
      end
      quiet();
      cycle(1'b1);

      // reset mid-DBUSY, late mack ignored
      dreq  = 1'b1;
      daddr = 32'h30;
      cycle(1'b1);
      cycle(1'b1);
      do_reset();
      dreq = 1'b0;
      mack = 1'b1;
      #1 check("rst_dready", dready, 0);
      check("rst_mreq", mreq, 0);
      cycle(1'b1);
      quiet();
      cycle(1'b1);

      // starvation / strict priority with both requesters saturated
      do_reset();
      ireq = 1'b1;
      dreq = 1'b1;
      mack = 1'b1;
      k    = 0;
      for (int c = 0; c < 20; c++) begin
         cycle(1'b1);
         if (s_ir || s_dr) begin
            check("starve_seq", s_ir, STARVE && (k % 5 == 4));
            k++;
         end
      end
      check("starve_cnt", k, 10);
      quiet();

      // zero-wait memory: one completion every two cycles
      do_reset();
      ireq = 1'b1;
      mack = 1'b1;
      k    = 0;
      for (int c = 0; c < 10; c++) begin
         cycle(1'b1);
         if (s_ir) k++;
      end
      check("zw_count", k, 5);
      quiet();
      do_reset();

      // random traffic
      i_act = 1'b0;
      d_act = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         if (last_ir) i_act = 1'b0;
         if (last_dr) d_act = 1'b0;
         if (!i_act && $urandom_range(2) == 0) begin
            i_act = 1'b1;
            iaddr = $urandom;
         end
         if (!d_act && $urandom_range(2) == 0) begin
            d_act  = 1'b1;
            daddr  = $urandom;
            dwe    = 1'($urandom_range(1));
            dwdata = $urandom;
         end
         ireq = i_act;
         if (i_act && m_busy == 1 && $urandom_range(3) == 0) ireq = 1'b0;
         dreq = d_act;
         if (d_act && m_busy == 2) begin
            if ($urandom_range(3) == 0) dreq = 1'b0;
            if ($urandom_range(1) == 0) begin
               daddr  = $urandom;
               dwdata = $urandom;
               dwe    = 1'($urandom_range(1));
            end
         end
         mack   = 1'($urandom_range(1));
         mrdata = $urandom;
         reset  = ($urandom_range(150) == 0);
         if (reset) mack = 1'b0;
         cycle(!reset);
         reset = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, 32, byte-address width on all ports.
REQ-002 The block SHALL have parameter DATA_W, 32, data width on all ports.
REQ-003 The block SHALL have parameter STARVE_LIMIT, 4, consecutive data grants allowed while ireq is pending.
REQ-004 The block SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 The block SHALL have port ireq  input  1  fetch-stage read request.
REQ-007 The block SHALL have port iaddr  input  ADDR_W  fetch address.
REQ-008 The block SHALL have port irdata  output  DATA_W  fetched instruction.
REQ-009 The block SHALL have port iready  output  1  fetch transaction complete.
REQ-010 The block SHALL have port istall  output  1  fetch stall (ireq & ~iready).
REQ-011 The block SHALL have port dreq  input  1  memory-stage request.
REQ-012 The block SHALL have port dwe  input  1  memory-stage write enable.
REQ-013 The block SHALL have port daddr  input  ADDR_W  data address.
REQ-014 The block SHALL have port dwdata  input  DATA_W  store data.
REQ-015 The block SHALL have port drdata  output  DATA_W  load data.
REQ-016 The block SHALL have port dready  output  1  data transaction complete.
REQ-017 The block SHALL have port dstall  output  1  data stall (dreq & ~dready).
REQ-018 The block SHALL have ports mreq, mwe  output  1  request and write enable to the shared single-port memory.
REQ-019 The block SHALL have ports maddr (ADDR_W) and mwdata (DATA_W)  output  memory address and write data.
REQ-020 The block SHALL have ports mrdata (DATA_W) and mack (1)  input  memory read data and completion.

Function
REQ-021 The FSM SHALL have states IDLE, IBUSY and DBUSY.
REQ-022 In IDLE, dreq SHALL win arbitration over ireq, except when the starvation override of REQ-035 applies.
REQ-023 On a grant, the FSM SHALL enter IBUSY or DBUSY and latch addr/we/wdata into internal registers; later requester changes SHALL be ignored until completion.
REQ-024 In IBUSY/DBUSY, mreq SHALL be 1 and maddr/mwe/mwdata SHALL come from the latched registers; in IDLE, mreq and mwe SHALL be 0.
REQ-025 IBUSY SHALL force mwe to 0.
REQ-026 In IBUSY with mack=1: iready=1 for that cycle only, irdata=mrdata, next state IDLE.
REQ-027 In DBUSY with mack=1: dready=1 for that cycle only, drdata=mrdata (don't-care on writes), next state IDLE.
REQ-028 mack while in IDLE SHALL be ignored.
REQ-029 Minimum latency SHALL be 2 cycles: request seen in IDLE in cycle 0, mreq in cycle 1, ready in cycle 1 if mack arrives in cycle 1; there SHALL be no upper bound while mack=0.
REQ-030 A requester SHALL hold its request until ready; a request dropped after grant SHALL still complete and still pulse ready.
REQ-031 Each IDLE cycle SHALL be followed by a grant whenever any request is pending (no idle bubble beyond the IDLE cycle itself).

Reset
REQ-032 While reset=1 at a clock edge: state SHALL become IDLE, latched registers 0 and starvation counter 0.
REQ-033 After that edge: mreq=0, mwe=0, iready=0, dready=0, irdata=0, drdata=0.
REQ-034 Reset mid-transaction SHALL abandon the transaction with no ready pulse; a late mack SHALL be ignored per REQ-028.

Configuration
REQ-035 With MEM_ARB_STARVE_EN defined: a counter SHALL increment on each data grant while ireq=1 and clear on any fetch grant or when ireq=0 in IDLE; when the counter equals STARVE_LIMIT, the next IDLE arbitration SHALL grant fetch even if dreq=1.
REQ-036 Without MEM_ARB_STARVE_EN: strict data priority, no counter logic, and STARVE_LIMIT SHALL be unused.

Structure
REQ-037 Package mem_arb_pkg SHALL hold the state enum (IDLE/IBUSY/DBUSY) and the default widths and STARVE_LIMIT constant.
REQ-038 The block SHALL have no sub-module; the FSM, latches and counter are single-module logic.

Verification
REQ-039 Single fetch: ireq=1, iaddr=0x0000_0040, mack one cycle after mreq with mrdata=0x2008_0005 -> mreq in cycle 1, iready pulse in cycle 2, irdata=0x2008_0005, istall=1 in cycles 0-1.
REQ-040 Collision: ireq and dreq rise together, dwe=1, daddr=0x54, dwdata=0x7 -> memory sees the write to 0x54 first; fetch is granted next IDLE; dstall and istall behave per REQ-010/017.
REQ-041 Address change after grant: daddr changes 0x10 -> 0x20 during DBUSY with mack delayed 3 cycles -> maddr stays 0x10 throughout.
REQ-042 Starvation (macro on, STARVE_LIMIT=4): dreq and ireq held high continuously -> grant sequence D,D,D,D,I,D...; with macro off, I is never granted while dreq=1.
REQ-043 Reset mid-DBUSY (mack=0), then mack=1 one cycle after reset -> no dready pulse; state IDLE; mreq=0 after the reset edge.
REQ-044 Zero-wait memory (mack tied 1), alternating requests -> one completion every 2 cycles; no double grant of a single request.
